// File: rtl/button_repeat_ctrl_pkg.sv
// Shared types and default 50 MHz timing for the push-button repeat conditioner.
// Holds the FSM state encoding and a helper that sizes the shared counter.
package btn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      HELD,
      REPEAT,
      DEB_RELEASE
   } btn_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
   localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;  // 500 ms
   localparam int unsigned DEF_REPEAT_CYCLES   = 5_000_000;   // 100 ms

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/button_repeat_ctrl_if.sv
// Button-side signal bundle: raw pin and repeat enable in, conditioned strobes out.
interface button_repeat_ctrl_if;

   logic btn_raw;
   logic repeat_en;
   logic add_pulse;
   logic pressed;
   logic release_pulse;
   logic repeating;

   modport master (
      output btn_raw, repeat_en,
      input  add_pulse, pressed, release_pulse, repeating
   );

   modport slave (
      input  btn_raw, repeat_en,
      output add_pulse, pressed, release_pulse, repeating
   );

endinterface

// File: rtl/button_repeat_ctrl_sync.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // NOTE: clocked state uses non-blocking assignments so both flops sample the
   // pre-edge values; blocking here would collapse the chain into one stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/button_repeat_ctrl.sv
// Debounces one push-button and emits a press strobe followed by auto-repeat
// strobes while held, plus a strobe on debounced release.
module button_repeat_ctrl
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input logic                 clk,
   input logic                 ResetActiveLow,
   button_repeat_ctrl_if.slave bus
);

   localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic btn_act;
   logic s;

   btn_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          add_pulse_q, add_pulse_d;
   logic          pressed_q, pressed_d;
   logic          release_pulse_q, release_pulse_d;
   logic          repeating_q, repeating_d;

   // Normalise to pressed = 1 before synchronising so the flops reset to "not pressed".
   assign btn_act = BTN_ACTIVE_LOW ? ~bus.btn_raw : bus.btn_raw;

   sync #(.RESET_VAL(1'b0)) u_sync (
      .clk   (clk),
      .rst_n (ResetActiveLow),
      .d     (btn_act),
      .q     (s)
   );

   // NOTE: every variable is given a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      add_pulse_d     = 1'b0;
      release_pulse_d = 1'b0;
      pressed_d       = pressed_q;

      unique case (state_q)
         IDLE: begin
            if (s) begin
               state_d = DEB_PRESS;
               cnt_d   = '0;
            end
         end
         DEB_PRESS: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = HELD;
               cnt_d       = '0;
               add_pulse_d = 1'b1;
               pressed_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!s) begin
               state_d = DEB_RELEASE;
               cnt_d   = '0;
            end else if (bus.repeat_en && (cnt_q == HOLD_LAST)) begin
               state_d     = REPEAT;
               cnt_d       = '0;
               add_pulse_d = 1'b1;
            end else if (bus.repeat_en) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         REPEAT: begin
            if (!s) begin
               state_d = DEB_RELEASE;
               cnt_d   = '0;
            end else if (!bus.repeat_en) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == REP_LAST) begin
               cnt_d       = '0;
               add_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DEB_RELEASE: begin
            // A bounce back to pressed restarts the hold delay without a new strobe.
            if (s) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d         = IDLE;
               cnt_d           = '0;
               pressed_d       = 1'b0;
               release_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      repeating_d = (state_d == REPEAT);
   end

   always_ff @(posedge clk or negedge ResetActiveLow) begin
      if (!ResetActiveLow) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         add_pulse_q     <= 1'b0;
         pressed_q       <= 1'b0;
         release_pulse_q <= 1'b0;
         repeating_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         add_pulse_q     <= add_pulse_d;
         pressed_q       <= pressed_d;
         release_pulse_q <= release_pulse_d;
         repeating_q     <= repeating_d;
      end
   end

   assign bus.add_pulse     = add_pulse_q;
   assign bus.pressed       = pressed_q;
   assign bus.release_pulse = release_pulse_q;
   assign bus.repeating     = repeating_q;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Directed bench for button_repeat_ctrl with short timing (D=4, H=10, R=3, active-low pin).
module tb_button_repeat_ctrl;

   localparam int D = 4;
   localparam int H = 10;
   localparam int R = 3;

   logic clk = 1'b0;
   logic ResetActiveLow = 1'b0;

   button_repeat_ctrl_if bus ();

   button_repeat_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .REPEAT_CYCLES   (R),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk            (clk),
      .ResetActiveLow (ResetActiveLow),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic btn;
      logic ren;
      logic add;
      logic prs;
      logic rel;
      logic rep;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one edge and settle just after it, away from the sampling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic add, input logic prs,
                             input logic rel, input logic rep);
      check({tag, ".add_pulse"},     {31'd0, bus.add_pulse},     {31'd0, add});
      check({tag, ".pressed"},       {31'd0, bus.pressed},       {31'd0, prs});
      check({tag, ".release_pulse"}, {31'd0, bus.release_pulse}, {31'd0, rel});
      check({tag, ".repeating"},     {31'd0, bus.repeating},     {31'd0, rep});
   endtask

   // 40 edges held pressed, then released; edge k is the k-th edge after pressing.
   task automatic run_hold(input logic ren);
      logic add, rep;
      for (int k = 1; k <= 50; k++) begin
         bus.btn_raw   = (k <= 40) ? 1'b0 : 1'b1;
         bus.repeat_en = ren;
         tick();
         if (ren) begin
            add = (k == 7) || (k >= 17 && k <= 41 && ((k - 17) % 3) == 0);
            rep = (k >= 17 && k <= 42);
         end else begin
            add = (k == 7);
            rep = 1'b0;
         end
         check_outs($sformatf("hold_ren%0d[%0d]", ren, k), add, (k >= 7 && k <= 46),
                    (k == 47), rep);
      end
   endtask

   task automatic settle();
      bus.btn_raw = 1'b1;
      for (int k = 0; k < 12; k++) tick();
   endtask

   initial begin
      bus.btn_raw   = 1'b0;
      bus.repeat_en = 1'b1;

      // Reset with the pin held pressed: everything quiet.
      #12;
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      bus.btn_raw = 1'b1;
      @(negedge clk);
      ResetActiveLow = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         check($sformatf("post_reset[%0d].add_pulse", k), {31'd0, bus.add_pulse}, 32'd0);
      end

      // Clean press held 8 edges, then released.
      for (int i = 1; i <= 20; i++)
         tbl.push_back('{btn: (i <= 8) ? 1'b0 : 1'b1, ren: 1'b1, add: (i == 7),
                         prs: (i >= 7 && i <= 14), rel: (i == 15), rep: 1'b0});
      // Bounce: 3 low, 2 high, 3 low, then high -- never debounced.
      for (int i = 1; i <= 16; i++)
         tbl.push_back('{btn: (i <= 3 || (i >= 6 && i <= 8)) ? 1'b0 : 1'b1, ren: 1'b1,
                         add: 1'b0, prs: 1'b0, rel: 1'b0, rep: 1'b0});

      foreach (tbl[i]) begin
         bus.btn_raw   = tbl[i].btn;
         bus.repeat_en = tbl[i].ren;
         tick();
         check_outs($sformatf("vec[%0d]", i), tbl[i].add, tbl[i].prs, tbl[i].rel, tbl[i].rep);
      end

      run_hold(1'b1);
      run_hold(1'b0);

      // repeat_en rises while HELD: hold count starts on that edge.
      for (int k = 1; k <= 26; k++) begin
         bus.btn_raw   = 1'b0;
         bus.repeat_en = (k >= 16);
         tick();
         check($sformatf("ren_rise[%0d].add_pulse", k), {31'd0, bus.add_pulse},
               {31'd0, (k == 7 || k == 25)});
         check($sformatf("ren_rise[%0d].repeating", k), {31'd0, bus.repeating},
               {31'd0, (k >= 25)});
      end
      settle();

      // Reset asserted mid-REPEAT, pin kept pressed through it.
      bus.repeat_en = 1'b1;
      bus.btn_raw   = 1'b0;
      for (int k = 1; k <= 20; k++) tick();
      check("mid_pre.repeating", {31'd0, bus.repeating}, 32'd1);
      #2;
      ResetActiveLow = 1'b0;
      #1;
      check_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ResetActiveLow = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("after_reset[%0d].add_pulse", k), {31'd0, bus.add_pulse},
               {31'd0, (k == D + 3)});
         check($sformatf("after_reset[%0d].pressed", k), {31'd0, bus.pressed},
               {31'd0, (k >= D + 3)});
      end
      settle();
      check_outs("final_idle", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
